ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Parametrised, registered control-word sequencer. It is the next-generation replacement for the purely combinational opcode-to-control-word stage.
- It takes the decoded control word from the decode ROM and sequences the following:
  - the boot/reset-vector cycle
  - prioritised multi-exception entry
  - external-interrupt entry
  - HLT parking
  - control-hazard field override
- It sits between the decode ROM and the ID/EX pipeline register. It drives fetch-hold and exception-vector selection to the fetch stage.

Parameters:
OPC_W, 7, opcode width
SIG_W, 41, control-word width
EXC_N, 4, number of exception request lines (index 0 = highest priority)
HLT_OPC, 7'b1100001, opcode that parks the core
NOP_WORD, 41'h000_0033_83A1, bubble word
BOOT_WORD, 41'h000_0F83_3823, reset-vector fetch word
PUSHPC_WORD, 41'h00E_0003_383B, entry step 1: push PC
PUSHFL_WORD, 41'h00E_0003_383F, entry step 2: push flags
VEC_WORD, 41'h040_0003_3823, entry step 3: load PC from vector table
HAZ_LSB, 24, LSB of hazard-override field
HAZ_W, 8, width of hazard-override field
HAZ_VAL, 8'h47, value forced into the field on ctrl_haz

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
hold  in  1  pipeline freeze: state and outputs hold
opcode  in  OPC_W  opcode of instruction in decode
dec_word  in  SIG_W  control word from decode ROM for opcode
ctrl_haz  in  1  control hazard detected this cycle
exc_req  in  EXC_N  level exception requests, held by source until acked
intr  in  1  external interrupt, level, edge-detected internally
signals  out  SIG_W  registered control word to ID/EX
exc_cause  out  CW  cause code, where CW = $clog2(EXC_N+1); value EXC_N = interrupt
exc_ack  out  EXC_N  one-hot one-cycle acknowledge of the serviced exception
fetch_hold  out  1  stall PC/fetch
halted  out  1  core parked on HLT

Behaviour:
- Reset is synchronous, active-high, and overrides hold. On a reset clock edge:
  - state = BOOT, signals = BOOT_WORD, exc_cause = 0, exc_ack = 0
  - intr_pend = 0, intr_q = 0, halted = 0, fetch_hold = 1
- Reset asserted mid-entry or while halted aborts to BOOT with no ack issued.
- All outputs are registered. A word chosen from inputs sampled at edge N appears after edge N.
- hold = 1: state, signals, exc_cause, halted and fetch_hold are unchanged; exc_ack is forced to 0. intr edge detection and intr_pend still update.
- intr_pend:
  - set on a 0->1 edge of intr (intr_q is a registered copy of intr)
  - cleared on the edge entering ENT0 for an interrupt
  - if set and clear occur together, set wins
- BOOT (one cycle): next state = RUN, signals = dec_word (with the hazard rule below), fetch_hold = 0.
- RUN, priority highest first:
  1. Any exc_req bit set:
     - cause = index of lowest set bit; exc_cause = cause
     - signals = PUSHPC_WORD, fetch_hold = 1, state -> ENT0
  2. intr_pend set: same as 1 with exc_cause = EXC_N.
  3. opcode == HLT_OPC: signals = dec_word, halted = 1, fetch_hold = 1, state -> HALT.
  4. Otherwise: signals = dec_word. If ctrl_haz, signals[HAZ_LSB +: HAZ_W] = HAZ_VAL.
- The hazard override applies only in case 4 and in the BOOT exit. It is never applied to NOP/entry words.
- ENT0 -> ENT1: signals = PUSHFL_WORD.
- ENT1 -> ENT2: signals = VEC_WORD.
- ENT2 -> RUN:
  - if cause < EXC_N, exc_ack[cause] = 1 for exactly this cycle
  - signals = NOP_WORD, fetch_hold = 0
- exc_req and intr are ignored during ENT0–ENT2 and BOOT. A newly pending request is taken in RUN on the first cycle after ENT2.
- HALT:
  - signals = NOP_WORD each cycle
  - leaves only on exc_req or intr_pend, which proceed as RUN cases 1/2 with halted cleared
  - opcode and ctrl_haz are ignored
- Entry latency: 3 sequencing words, then a NOP. An instruction is not re-decoded before the fetch_hold release plus one cycle.

Test Plan:
- Reset with hold = 1 for 2 cycles, then release with opcode = ADD 7'b0000001 and dec_word = D → BOOT_WORD and fetch_hold = 1 on the first edge, then D on the next edge, fetch_hold = 0.
- RUN, exc_req = 4'b1010 held → PUSHPC, PUSHFL, VEC_WORD then NOP; exc_cause = 1; exc_ack = 4'b0010 on the NOP cycle only. The source drops bit 1 and keeps bit 3 → a second entry follows with exc_cause = 3 and exc_ack = 4'b1000.
- intr pulse of 1 cycle during ENT1 of an exception entry → pend retained; after the first entry, a second entry with exc_cause = 4 and no exc_ack bit.
- opcode = 7'b1100001 → halted = 1, NOP_WORD repeated 10 cycles; intr 0->1 → halted = 0, entry sequence, exc_cause = 4.
- ctrl_haz = 1 with dec_word = 0 in RUN → signals = 41'h000_4700_0000. Same in ENT1 → PUSHFL_WORD unmodified.
- Reset asserted in ENT1 → next cycle BOOT_WORD, exc_ack = 0, exc_cause = 0, intr_pend = 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Brief    : Registered control-word sequencer (boot, exception/interrupt
//            entry, HLT parking, control-hazard field override).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
    parameter int               OPC_W       = 7,
    parameter int               SIG_W       = 41,
    parameter int               EXC_N       = 4,
    parameter logic [OPC_W-1:0] HLT_OPC     = 7'b1100001,
    parameter logic [SIG_W-1:0] NOP_WORD    = 41'h000_0033_83A1,
    parameter logic [SIG_W-1:0] BOOT_WORD   = 41'h000_0F83_3823,
    parameter logic [SIG_W-1:0] PUSHPC_WORD = 41'h00E_0003_383B,
    parameter logic [SIG_W-1:0] PUSHFL_WORD = 41'h00E_0003_383F,
    parameter logic [SIG_W-1:0] VEC_WORD    = 41'h040_0003_3823,
    parameter int               HAZ_LSB     = 24,
    parameter int               HAZ_W       = 8,
    parameter logic [HAZ_W-1:0] HAZ_VAL     = 8'h47,
    localparam int              CW          = $clog2(EXC_N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [OPC_W-1:0] opcode,
    input  logic [SIG_W-1:0] dec_word,
    input  logic             ctrl_haz,
    input  logic [EXC_N-1:0] exc_req,
    input  logic             intr,
    output logic [SIG_W-1:0] signals,
    output logic [CW-1:0]    exc_cause,
    output logic [EXC_N-1:0] exc_ack,
    output logic             fetch_hold,
    output logic             halted
);

    localparam logic [CW-1:0] C_CAUSE_INTR = CW'(EXC_N);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_RUN  = 3'd1,
        S_ENT0 = 3'd2,
        S_ENT1 = 3'd3,
        S_ENT2 = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_intr_q;
    logic             r_intr_pend;
    logic             w_intr_edge;
    logic             w_pend_clr;
    logic [CW-1:0]    w_exc_idx;
    logic [SIG_W-1:0] w_haz_word;
    logic [SIG_W-1:0] w_signals_nxt;
    logic [CW-1:0]    w_cause_nxt;
    logic [EXC_N-1:0] w_ack_nxt;
    logic             w_fetch_hold_nxt;
    logic             w_halted_nxt;

    assign w_intr_edge = intr & ~r_intr_q;

    // Lowest set request bit wins; scanning downward leaves the lowest index.
    always_comb begin
        w_exc_idx = '0;
        for (int i = EXC_N - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                w_exc_idx = CW'(i);
            end
        end
    end

    always_comb begin
        w_haz_word = dec_word;
        if (ctrl_haz) begin
            w_haz_word[HAZ_LSB +: HAZ_W] = HAZ_VAL;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_signals_nxt    = signals;
        w_cause_nxt      = exc_cause;
        w_ack_nxt        = '0;
        w_fetch_hold_nxt = fetch_hold;
        w_halted_nxt     = halted;
        w_pend_clr       = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_state_nxt      = S_RUN;
                w_signals_nxt    = w_haz_word;
                w_fetch_hold_nxt = 1'b0;
            end
            S_RUN, S_HALT: begin
                if (|exc_req) begin
                    w_state_nxt      = S_ENT0;
                    w_signals_nxt    = PUSHPC_WORD;
                    w_cause_nxt      = w_exc_idx;
                    w_fetch_hold_nxt = 1'b1;
                    w_halted_nxt     = 1'b0;
                end else if (r_intr_pend) begin
                    w_state_nxt      = S_ENT0;
                    w_signals_nxt    = PUSHPC_WORD;
                    w_cause_nxt      = C_CAUSE_INTR;
                    w_fetch_hold_nxt = 1'b1;
                    w_halted_nxt     = 1'b0;
                    w_pend_clr       = 1'b1;
                end else if (r_state == S_HALT) begin
                    w_signals_nxt = NOP_WORD;
                end else if (opcode == HLT_OPC) begin
                    w_state_nxt      = S_HALT;
                    w_signals_nxt    = dec_word;
                    w_fetch_hold_nxt = 1'b1;
                    w_halted_nxt     = 1'b1;
                end else begin
                    w_signals_nxt    = w_haz_word;
                    w_fetch_hold_nxt = 1'b0;
                end
            end
            S_ENT0: begin
                w_state_nxt   = S_ENT1;
                w_signals_nxt = PUSHFL_WORD;
            end
            S_ENT1: begin
                w_state_nxt   = S_ENT2;
                w_signals_nxt = VEC_WORD;
            end
            S_ENT2: begin
                w_state_nxt      = S_RUN;
                w_signals_nxt    = NOP_WORD;
                w_fetch_hold_nxt = 1'b0;
                if (exc_cause != C_CAUSE_INTR) begin
                    w_ack_nxt = EXC_N'(1) << exc_cause;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_BOOT;
            signals     <= BOOT_WORD;
            exc_cause   <= '0;
            exc_ack     <= '0;
            fetch_hold  <= 1'b1;
            halted      <= 1'b0;
            r_intr_q    <= 1'b0;
            r_intr_pend <= 1'b0;
        end else begin
            r_intr_q <= intr;
            // A fresh edge beats a simultaneous clear.
            r_intr_pend <= w_intr_edge | (r_intr_pend & ~(w_pend_clr & ~hold));
            if (hold) begin
                exc_ack <= '0;
            end else begin
                r_state    <= w_state_nxt;
                signals    <= w_signals_nxt;
                exc_cause  <= w_cause_nxt;
                exc_ack    <= w_ack_nxt;
                fetch_hold <= w_fetch_hold_nxt;
                halted     <= w_halted_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Brief    : Directed self-checking bench for ctrl_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

    localparam logic [40:0] NOP_W    = 41'h000_0033_83A1;
    localparam logic [40:0] BOOT_W   = 41'h000_0F83_3823;
    localparam logic [40:0] PUSHPC_W = 41'h00E_0003_383B;
    localparam logic [40:0] PUSHFL_W = 41'h00E_0003_383F;
    localparam logic [40:0] VEC_W    = 41'h040_0003_3823;
    localparam logic [40:0] HAZ_RES  = 41'h000_4700_0000;
    localparam logic [40:0] D_W      = 41'h0AB_CDEF_1234;
    localparam logic [6:0]  ADD_OPC  = 7'b0000001;
    localparam logic [6:0]  HLT      = 7'b1100001;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [6:0]  opcode;
    logic [40:0] dec_word;
    logic        ctrl_haz;
    logic [3:0]  exc_req;
    logic        intr;
    logic [40:0] signals;
    logic [2:0]  exc_cause;
    logic [3:0]  exc_ack;
    logic        fetch_hold;
    logic        halted;

    int tests = 0;
    int fails = 0;

    ctrl_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .opcode     (opcode),
        .dec_word   (dec_word),
        .ctrl_haz   (ctrl_haz),
        .exc_req    (exc_req),
        .intr       (intr),
        .signals    (signals),
        .exc_cause  (exc_cause),
        .exc_ack    (exc_ack),
        .fetch_hold (fetch_hold),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sig(input string tag, input logic [40:0] exp);
        tests++;
        assert (signals === exp) else begin
            fails++;
            $error("FAIL %s signals: observed %h expected %h", tag, signals, exp);
        end
    endtask

    // Packed as {fetch_hold, halted, exc_cause[2:0], exc_ack[3:0]}.
    task automatic chk_ctl(input string tag, input logic fh, input logic hl,
                           input logic [2:0] cause, input logic [3:0] ack);
        tests++;
        assert ({fetch_hold, halted, exc_cause, exc_ack} === {fh, hl, cause, ack}) else begin
            fails++;
            $error("FAIL %s ctl{fh,hlt,cause,ack}: observed %b expected %b", tag,
                   {fetch_hold, halted, exc_cause, exc_ack}, {fh, hl, cause, ack});
        end
    endtask

    initial begin
        reset = 1'b1; hold = 1'b1; opcode = ADD_OPC; dec_word = D_W;
        ctrl_haz = 1'b0; exc_req = 4'b0000; intr = 1'b0;

        // Reset dominates hold.
        tick(); chk_sig("rst0", BOOT_W); chk_ctl("rst0", 1, 0, 3'd0, 4'b0000);
        tick(); chk_sig("rst1", BOOT_W); chk_ctl("rst1", 1, 0, 3'd0, 4'b0000);
        reset = 1'b0; hold = 1'b0;
        tick(); chk_sig("boot_exit", D_W); chk_ctl("boot_exit", 0, 0, 3'd0, 4'b0000);
        tick(); chk_sig("run_add", D_W);

        // Two-bit request: lowest index serviced first.
        exc_req = 4'b1010;
        tick(); chk_sig("e1_pushpc", PUSHPC_W); chk_ctl("e1_ent0", 1, 0, 3'd1, 4'b0000);
        tick(); chk_sig("e1_pushfl", PUSHFL_W);
        tick(); chk_sig("e1_vec", VEC_W); chk_ctl("e1_ent2", 1, 0, 3'd1, 4'b0000);
        hold = 1'b1;
        tick(); chk_sig("e1_hold", VEC_W); chk_ctl("e1_hold", 1, 0, 3'd1, 4'b0000);
        hold = 1'b0;
        tick(); chk_sig("e1_nop", NOP_W); chk_ctl("e1_ack", 0, 0, 3'd1, 4'b0010);
        exc_req = 4'b1000;
        tick(); chk_sig("e2_pushpc", PUSHPC_W); chk_ctl("e2_ent0", 1, 0, 3'd3, 4'b0000);
        tick(); chk_sig("e2_pushfl", PUSHFL_W);
        intr = 1'b1;
        tick(); chk_sig("e2_vec", VEC_W);
        intr = 1'b0;
        tick(); chk_sig("e2_nop", NOP_W); chk_ctl("e2_ack", 0, 0, 3'd3, 4'b1000);
        exc_req = 4'b0000;

        // Interrupt pended during the previous entry.
        tick(); chk_sig("i1_pushpc", PUSHPC_W); chk_ctl("i1_ent0", 1, 0, 3'd4, 4'b0000);
        tick(); chk_sig("i1_pushfl", PUSHFL_W);
        tick(); chk_sig("i1_vec", VEC_W);
        tick(); chk_sig("i1_nop", NOP_W); chk_ctl("i1_noack", 0, 0, 3'd4, 4'b0000);
        tick(); chk_sig("run_after_i1", D_W);

        dec_word = '0; ctrl_haz = 1'b1;
        tick(); chk_sig("haz_run", HAZ_RES);
        ctrl_haz = 1'b0; dec_word = D_W;

        // HLT parking; ctrl_haz must not affect the parked NOP.
        opcode = HLT;
        tick(); chk_sig("hlt_enter", D_W); chk_ctl("hlt_enter", 1, 1, 3'd4, 4'b0000);
        ctrl_haz = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); chk_sig("hlt_nop", NOP_W); chk_ctl("hlt_park", 1, 1, 3'd4, 4'b0000);
        end
        intr = 1'b1;
        tick(); chk_sig("hlt_pendset", NOP_W);
        tick(); chk_sig("hlt_pushpc", PUSHPC_W); chk_ctl("hlt_exit", 1, 0, 3'd4, 4'b0000);
        opcode = ADD_OPC; dec_word = '0;
        tick(); chk_sig("haz_ent1", PUSHFL_W);
        ctrl_haz = 1'b0; dec_word = D_W;
        tick(); chk_sig("h_vec", VEC_W);
        tick(); chk_sig("h_nop", NOP_W); chk_ctl("h_noack", 0, 0, 3'd4, 4'b0000);
        intr = 1'b0;
        tick(); chk_sig("run_after_h", D_W);

        // Reset during ENT1 with an interrupt pending.
        exc_req = 4'b0001;
        tick(); chk_sig("e3_pushpc", PUSHPC_W); chk_ctl("e3_ent0", 1, 0, 3'd0, 4'b0000);
        intr = 1'b1;
        tick(); chk_sig("e3_pushfl", PUSHFL_W);
        intr = 1'b0; reset = 1'b1; exc_req = 4'b0000;
        tick(); chk_sig("abort_boot", BOOT_W); chk_ctl("abort", 1, 0, 3'd0, 4'b0000);
        reset = 1'b0;
        tick(); chk_sig("abort_exit", D_W); chk_ctl("abort_exit", 0, 0, 3'd0, 4'b0000);
        tick(); chk_sig("pend_cleared", D_W); chk_ctl("pend_cleared", 0, 0, 3'd0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
